// File: rtl/alu_arbiter_if.sv
// Host/ALU bundle for alu_arbiter: two request ports, the shared-ALU drive side and the result return.
// slave = arbiter view, master = host + ALU view (a testbench drives both sides).
interface alu_arbiter_if #(
  parameter int DW = 8
);
  logic              req0;
  logic              req1;
  logic [1:0]        op0;
  logic [1:0]        op1;
  logic [DW-1:0]     a0;
  logic [DW-1:0]     b0;
  logic [DW-1:0]     a1;
  logic [DW-1:0]     b1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [2*DW-1:0]   res;
  logic              err;
  logic              busy;
  logic              owner;
  logic              alu_start;
  logic [1:0]        alu_sel;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic              alu_finish;
  logic [2*DW-1:0]   alu_res;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_finish, alu_res,
    output gnt0, gnt1, done0, done1, res, err, busy, owner,
           alu_start, alu_sel, alu_a, alu_b
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_finish, alu_res,
    input  gnt0, gnt1, done0, done1, res, err, busy, owner,
           alu_start, alu_sel, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Optional watchdog: define ALU_ARB_TIMEOUT_EN to abort runs after TO_CYCLES wait cycles.
module alu_arbiter #(
  parameter int DW        = 8,
  parameter int TO_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last;
  logic [1:0]        r_sel;
  logic [DW-1:0]     r_a;
  logic [DW-1:0]     r_b;
  logic [2*DW-1:0]   r_res;
  logic              w_grant;
  logic              w_winner;
  logic              w_capture;
  logic              w_timeout;
  logic              w_waiting;

  if (TO_CYCLES < 2) begin : g_cfg_check
    $error("alu_arbiter: TO_CYCLES must be at least 2");
  end

  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_grant  = (bus.req0 | bus.req1) & bus.alu_finish;
    w_winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      w_winner = ~r_last;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Fires on the wait cycle whose increment would make the count reach TO_CYCLES.
  assign w_timeout = w_waiting && (r_cnt == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_waiting) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = (r_state == S_RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout)             w_state_nxt = S_RESP;
        else if (!bus.alu_finish)  w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_timeout) begin
          w_state_nxt = S_RESP;
        end else if (bus.alu_finish) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_sel   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_grant) begin
        r_owner <= w_winner;
        r_sel   <= w_winner ? bus.op1 : bus.op0;
        r_a     <= w_winner ? bus.a1  : bus.a0;
        r_b     <= w_winner ? bus.b1  : bus.b0;
      end
      if (r_state == S_ISSUE) begin
        r_last <= r_owner;
      end
      if (w_capture) begin
        r_res <= bus.alu_res;
      end else if (w_timeout) begin
        r_res <= '0;
      end
    end
  end

  assign bus.gnt0      = (r_state == S_ISSUE) && !r_owner;
  assign bus.gnt1      = (r_state == S_ISSUE) &&  r_owner;
  assign bus.alu_start = (r_state == S_ISSUE);
  assign bus.done0     = (r_state == S_RESP)  && !r_owner;
  assign bus.done1     = (r_state == S_RESP)  &&  r_owner;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.owner     = r_owner;
  assign bus.res       = r_res;
  assign bus.alu_sel   = r_sel;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, scoreboard on done, vector table plus corner sequences.
module tb_alu_arbiter;

  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct {
    bit          who;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] exp_res;
  } vec_t;

  typedef struct {
    bit          who;
    logic [15:0] res;
    bit          err;
  } sb_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  alu_arbiter_if #(.DW(DW)) bus ();

  alu_arbiter #(.DW(DW), .TO_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic       model_fin;
  logic       ext_busy;
  int         alu_lat;
  bit         alu_hang;
  bit         to_expect;
  logic [1:0] exp_op [2];
  logic [7:0] exp_a  [2];
  logic [7:0] exp_b  [2];
  sb_t        sb [$];
  bit         gnt_who_log [$];
  int         gnt_cyc_log [$];

  assign bus.alu_finish = model_fin & ~ext_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sbv;
    sa  = {{8{a[7]}}, a};
    sbv = {{8{b[7]}}, b};
    case (op)
      2'b00:   return sa + sbv;
      2'b01:   return sa - sbv;
      2'b10:   return sa * sbv;
      default: return (b == 8'h00) ? 16'hFFFF : {a % b, a / b};
    endcase
  endfunction

  // Behavioural ALU: finish drops the cycle after start and stays low alu_lat cycles.
  initial begin
    logic [15:0] res_q;
    int          n;
    model_fin   = 1'b1;
    bus.alu_res = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.alu_start) begin
        res_q = alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
        @(posedge clk);
        #1;
        if (!rst) begin
          model_fin   = 1'b0;
          bus.alu_res = 16'hDEAD;
          n = 0;
          while (!rst && (alu_hang || n < alu_lat)) begin
            @(posedge clk);
            #1;
            n++;
          end
          bus.alu_res = rst ? 16'h0000 : res_q;
        end
        model_fin = 1'b1;
      end
    end
  end

  // Monitor: grants push expectations, dones pop and compare.
  initial begin
    sb_t e;
    bit  w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.gnt0 || bus.gnt1) begin
          check("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
          w = bus.gnt1;
          e.who = w;
          e.err = to_expect;
          e.res = to_expect ? 16'h0000 : alu_ref(exp_op[w], exp_a[w], exp_b[w]);
          sb.push_back(e);
          gnt_who_log.push_back(w);
          gnt_cyc_log.push_back(cyc);
        end
        if (bus.err) check("err_with_done", bus.done0 | bus.done1, 1);
        if (bus.done0 || bus.done1) begin
          check("done_onehot", bus.done0 & bus.done1, 0);
          check("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_done_owner", bus.done1, e.who);
            check("sb_owner_out", bus.owner, e.who);
            check("sb_res", bus.res, e.res);
            check("sb_err", bus.err, e.err);
          end
        end
      end
    end
  end

  task automatic drive_req(input bit who, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_op[who] = op;
    exp_a[who]  = a;
    exp_b[who]  = b;
    if (who) begin
      bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    end else begin
      bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    end
  endtask

  task automatic wait_gnt(output int c, output bit who);
    bit found = 1'b0;
    c = -1; who = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        found = 1'b1; c = cyc; who = bus.gnt1;
      end
    end
    check("gnt_seen", found, 1);
  endtask

  task automatic wait_done(output int c, output bit who);
    bit found = 1'b0;
    c = -1; who = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        found = 1'b1; c = cyc; who = bus.done1;
      end
    end
    check("done_seen", found, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy && (sb.size() == 0);
    end
    check("idle_reached", idle, 1);
  endtask

  initial begin
    vec_t vecs[6];
    int   t, cg, cd, t_rel;
    bit   w;
    int   ngnt;

    vecs[0] = '{who: 1'b0, op: 2'b00, a: 8'h05, b: 8'h03, lat: 4, exp_res: 16'h0008};
    vecs[1] = '{who: 1'b1, op: 2'b01, a: 8'h03, b: 8'h05, lat: 1, exp_res: 16'hFFFE};
    vecs[2] = '{who: 1'b0, op: 2'b10, a: 8'hFD, b: 8'h04, lat: 3, exp_res: 16'hFFF4};
    vecs[3] = '{who: 1'b1, op: 2'b11, a: 8'h07, b: 8'h02, lat: 2, exp_res: 16'h0103};
    vecs[4] = '{who: 1'b0, op: 2'b10, a: 8'h7F, b: 8'h7F, lat: 5, exp_res: 16'h3F01};
    vecs[5] = '{who: 1'b1, op: 2'b00, a: 8'hFF, b: 8'h01, lat: 1, exp_res: 16'h0000};

    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    ext_busy = 1'b0; alu_hang = 1'b0; alu_lat = 1; to_expect = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0; bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(negedge clk);

    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_done0", bus.done0, 0);
    check("rst_done1", bus.done1, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_res", bus.res, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    check("rst_owner", bus.owner, 0);
    rst = 1'b0;

    // Tie after reset and fairness: both held for six operations, N=2.
    @(negedge clk);
    alu_lat = 2;
    gnt_who_log.delete();
    gnt_cyc_log.delete();
    drive_req(1'b0, 2'b00, 8'h10, 8'h20);
    drive_req(1'b1, 2'b01, 8'h50, 8'h08);
    ngnt = 0;
    for (int i = 0; i < 200 && ngnt < 6; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) ngnt++;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("fair_six_grants", ngnt, 6);
    wait_idle();
    check("fair_log_len", gnt_who_log.size(), 6);
    for (int i = 0; i < gnt_who_log.size() && i < 6; i++) begin
      check($sformatf("fair_owner_%0d", i), gnt_who_log[i], i % 2);
      if (i > 0) check($sformatf("fair_spacing_%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], 2 + 4);
    end

    // Table of single operations.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      alu_lat = vecs[i].lat;
      t = cyc;
      drive_req(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_gnt(cg, w);
      if (vecs[i].who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      check($sformatf("v%0d_gnt_owner", i), w, vecs[i].who);
      check($sformatf("v%0d_gnt_lat", i), cg - t, 1);
      check($sformatf("v%0d_alu_sel", i), bus.alu_sel, vecs[i].op);
      check($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].a);
      check($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].b);
      wait_done(cd, w);
      check($sformatf("v%0d_done_owner", i), w, vecs[i].who);
      check($sformatf("v%0d_done_lat", i), cd - t, vecs[i].lat + 3);
      check($sformatf("v%0d_res", i), bus.res, vecs[i].exp_res);
    end

    // Operand stability: host inputs change right after the grant.
    wait_idle();
    alu_lat = 3;
    drive_req(1'b0, 2'b10, 8'hFD, 8'h04);
    wait_gnt(cg, w);
    bus.req0 = 1'b0;
    bus.a0   = 8'h11;
    bus.op0  = 2'b00;
    w = 1'b0;
    for (int i = 0; i < 30 && !w; i++) begin
      @(negedge clk);
      check("stab_alu_sel", bus.alu_sel, 2'b10);
      check("stab_alu_a", bus.alu_a, 8'hFD);
      w = bus.done0 | bus.done1;
    end
    check("stab_res", bus.res, 16'hFFF4);

    // ALU busy from elsewhere blocks grants in IDLE.
    wait_idle();
    alu_lat = 1;
    ext_busy = 1'b1;
    drive_req(1'b0, 2'b00, 8'h01, 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blocked_no_gnt", bus.gnt0 | bus.gnt1, 0);
    end
    ext_busy = 1'b0;
    t_rel = cyc;
    wait_gnt(cg, w);
    bus.req0 = 1'b0;
    check("blocked_gnt_lat", cg - t_rel, 1);
    wait_idle();

    // Reset in WAIT_DONE with requester 1 waiting.
    alu_lat = 10;
    drive_req(1'b0, 2'b00, 8'h02, 8'h02);
    wait_gnt(cg, w);
    bus.req0 = 1'b0;
    drive_req(1'b1, 2'b01, 8'h09, 8'h04);
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_done", bus.done0 | bus.done1, 0);
    check("rstmid_res", bus.res, 0);
    check("rstmid_start", bus.alu_start, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    t_rel = cyc;
    wait_gnt(cg, w);
    bus.req1 = 1'b0;
    check("rstmid_gnt_owner", w, 1);
    check("rstmid_gnt_lat", cg - t_rel, 1);
    wait_done(cd, w);
    check("rstmid_done_owner", w, 1);
    check("rstmid_res_after", bus.res, 16'h0005);

`ifdef ALU_ARB_TIMEOUT_EN
    // Watchdog: ALU never finishes.
    wait_idle();
    alu_hang = 1'b1;
    to_expect = 1'b1;
    t = cyc;
    drive_req(1'b0, 2'b10, 8'h02, 8'h03);
    wait_gnt(cg, w);
    bus.req0 = 1'b0;
    @(negedge clk);
    to_expect = 1'b0;
    wait_done(cd, w);
    check("to_done_lat", cd - t, 2 + TO);
    check("to_owner", w, 0);
    check("to_err", bus.err, 1);
    check("to_res", bus.res, 0);
    alu_hang = 1'b0;
`endif

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the ALU (add/sub/Booth multiply/divide, sequenced by `control_unit`) between two requesters, with round-robin fairness.
- Latches the granted requester's opcode and operands, then drives `start`/`sel`/operands to the ALU.
- Tracks the ALU `finish` handshake, captures the result and returns a one-cycle `done` to the owner.
- Sits between the host-side request ports and the ALU top level.

## Interface
- `DW`, 8: operand width; result is `2*DW`.
- `TO_CYCLES`, 64: watchdog limit in cycles (used only with the macro).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`, `req1`  in  1  request; held high with op/operands stable until `gnt`.
- `op0`, `op1`  in  2  opcode, ALU `sel` encoding (00 add, 01 sub, 10 mul, 11 div).
- `a0`, `b0`, `a1`, `b1`  in  DW  operands.
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted, operands latched.
- `done0`, `done1`  out  1  one-cycle pulse: `res` valid for that owner.
- `res`  out  2*DW  result register; holds its value until the next capture.
- `err`  out  1  one-cycle pulse with `done`: operation timed out.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  index of the current/last granted requester.
- `alu_start`  out  1  start pulse to the ALU control unit.
- `alu_sel`  out  2  opcode to the ALU; held stable from ISSUE through the capture cycle.
- `alu_a`, `alu_b`  out  DW  latched operands; held stable likewise.
- `alu_finish`  in  1  ALU idle/finished flag (high when ALU is idle).
- `alu_res`  in  2*DW  ALU result, valid while `alu_finish` is high after a run.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Grants when any request is high and `alu_finish`=1.
  - Single request: that requester wins.
  - Both requesting: winner is the one not equal to the round-robin pointer `last`.
  - On grant: latch op/a/b into the ALU-side registers, set `owner`, go to ISSUE.
- ISSUE (1 cycle): `gnt[owner]`=1 and `alu_start`=1; update `last`=`owner`; go to WAIT_BUSY.
- WAIT_BUSY: stay while `alu_finish`=1; on `alu_finish`=0 go to WAIT_DONE.
- WAIT_DONE:
  - Stay while `alu_finish`=0.
  - On `alu_finish`=1: `res`<=`alu_res`, go to RESP.
- RESP (1 cycle): `done[owner]`=1; go to IDLE.
- Requests are not sampled outside IDLE. A `req` still high after its `gnt` is treated as a new request.
- Requests are never dropped. A losing requester keeps `req` high and is granted on the next IDLE.
- `rst` does not reset the ALU. The ALU shares the same `rst`, so both return to idle together.

## Timing
- Reset values:
  - Outputs: `gnt*`, `done*`, `err`, `busy`, `alu_start` = 0; `res`, `alu_a`, `alu_b`, `alu_sel` = 0; `owner` = 0.
  - Internal: state = IDLE; `last` = 1, so requester 0 wins the first tie.
- Grant latency: request sampled in IDLE at cycle t → `gnt`/`alu_start` at t+1.
- Done latency: if the ALU holds `finish` low for N≥1 cycles starting at t+2, `done` asserts at t+N+3.
- Back-to-back: the next grant can be sampled in the IDLE cycle right after RESP. Minimum spacing between `gnt` pulses is N+4 cycles.
- `alu_sel`/`alu_a`/`alu_b` change only in the IDLE grant cycle.
- Reset mid-operation:
  - Immediate return to IDLE, all pulses cleared.
  - `res` clears to 0; no `done` is issued for the aborted operation.
- Simultaneous events:
  - A request arriving during RESP is seen in the following IDLE cycle.
  - `alu_finish`=0 in IDLE blocks grants; the ALU is busy from an external source.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears in ISSUE and increments in WAIT_BUSY/WAIT_DONE.
  - When it reaches `TO_CYCLES`, go to RESP with `res`=0 and `err`=1 alongside `done[owner]`.
- Not defined: no counter; `err` tied to 0; the FSM waits on `alu_finish` indefinitely.

## Test plan
- Single add:
  - Stimulus: `req0`, op=00, a=8'h05, b=8'h03; ALU model holds `finish` low 4 cycles.
  - Required: `gnt0` at t+1 with `alu_sel`=00; `done0` at t+7; `res`=16'h0008.
- Tie after reset:
  - Stimulus: `req0` and `req1` high together.
  - Required: requester 0 granted first, requester 1 granted next; `gnt1` exactly 4+N cycles after `gnt0`.
- Fairness:
  - Stimulus: both requesters hold `req` high for 6 operations.
  - Required: grants alternate 0,1,0,1,0,1; no `done` goes to the wrong owner.
- Stability:
  - Stimulus: multiply, op=10, a=8'hFD, b=8'h04; change `a0`/`op0` after `gnt0`.
  - Required: `alu_sel`/`alu_a` unchanged until RESP; `res`=16'hFFF4.
- Reset mid-run:
  - Stimulus: assert `rst` in WAIT_DONE.
  - Required: same cycle, `busy`=0 and no `done`; after release, a held `req1` is granted first (pointer reset favours 0 only on a tie).
- Timeout (macro on, `TO_CYCLES`=16):
  - Stimulus: ALU model never raises `finish`.
  - Required: `done0`=1 with `err`=1 and `res`=0 exactly 16 cycles after WAIT_BUSY entry.
